// File: rtl/rca_config_pkg.sv
// Shared types, widths and helpers for the RCA configuration unit.
// Optional build macro: RCA_CFG_CHECK_EN (adds malformed-instruction checking).
package rca_config_pkg;

   localparam int NUM_RCAS           = 4;
   localparam int NUM_READ_PORTS     = 5;
   localparam int NUM_WRITE_PORTS    = 2;
   localparam int NUM_GRID_MUXES     = 16;
   localparam int GRID_MUX_INPUTS    = 8;
   localparam int GRID_NUM_ROWS      = 4;
   localparam int IO_UNIT_MUX_INPUTS = 8;
   localparam int MAX_IDS            = 8;

   localparam int RCA_W       = $clog2(NUM_RCAS);
   localparam int ID_W        = $clog2(MAX_IDS);
   localparam int CNT_W       = ID_W + 1;
   localparam int REG_W       = 5;
   localparam int PORT_W      = $clog2(NUM_READ_PORTS);
   localparam int GRID_SEL_W  = $clog2(GRID_MUX_INPUTS);
   // One spare bit so an out-of-range grid address is representable.
   localparam int GRID_ADDR_W = $clog2(NUM_GRID_MUXES) + 1;
   localparam int IO_SEL_W    = $clog2(IO_UNIT_MUX_INPUTS);
   localparam int IO_ADDR_W   = $clog2(GRID_NUM_ROWS);
   localparam int RES_SEL_W   = $clog2(GRID_NUM_ROWS);
   localparam int RES_ADDR_W  = $clog2(NUM_WRITE_PORTS);

   typedef logic [ID_W-1:0] id_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_APPLY = 2'd2
   } rca_cfg_state_t;

   typedef struct packed {
      logic [RCA_W-1:0]       rca_sel;
      logic                   cfg_cpu_reg;
      logic                   cfg_grid;
      logic                   cfg_io;
      logic                   cfg_result;
      logic [PORT_W-1:0]      cpu_port_sel;
      logic                   cpu_src_dest_port;
      logic [REG_W-1:0]       cpu_reg_addr;
      logic [GRID_ADDR_W-1:0] grid_mux_addr;
      logic [GRID_SEL_W-1:0]  new_grid_mux_sel;
      logic [IO_ADDR_W-1:0]   io_mux_addr;
      logic [IO_SEL_W-1:0]    new_io_mux_sel;
      logic [RES_ADDR_W-1:0]  rca_result_mux_addr;
      logic [RES_SEL_W-1:0]   new_rca_result_mux_sel;
   } rca_inputs_t;

   typedef struct packed {
      logic [NUM_READ_PORTS-1:0][REG_W-1:0]  src;
      logic [NUM_WRITE_PORTS-1:0][REG_W-1:0] dest;
   } rca_config_t;

   typedef struct packed {
      logic [NUM_READ_PORTS-1:0][REG_W-1:0]      src;
      logic [NUM_WRITE_PORTS-1:0][REG_W-1:0]     dest;
      logic [NUM_GRID_MUXES-1:0][GRID_SEL_W-1:0] grid;
      logic [GRID_NUM_ROWS-1:0][IO_SEL_W-1:0]    io;
      logic [NUM_WRITE_PORTS-1:0][RES_SEL_W-1:0] res;
   } rca_cfg_bank_t;

   // Single field update; when several flags are set the highest priority
   // one (cpu > grid > io > result) wins. Out-of-range indices write nothing.
   function automatic rca_cfg_bank_t apply_cfg(input rca_cfg_bank_t b, input rca_inputs_t c);
      rca_cfg_bank_t n;
      n = b;
      if (c.cfg_cpu_reg) begin
         if (!c.cpu_src_dest_port) begin
            if (c.cpu_port_sel < PORT_W'(NUM_READ_PORTS))
               n.src[c.cpu_port_sel] = c.cpu_reg_addr;
         end else if (c.cpu_port_sel < PORT_W'(NUM_WRITE_PORTS)) begin
            n.dest[c.cpu_port_sel[RES_ADDR_W-1:0]] = c.cpu_reg_addr;
         end
      end else if (c.cfg_grid) begin
         if (c.grid_mux_addr < GRID_ADDR_W'(NUM_GRID_MUXES))
            n.grid[c.grid_mux_addr[GRID_ADDR_W-2:0]] = c.new_grid_mux_sel;
      end else if (c.cfg_io) begin
         n.io[c.io_mux_addr] = c.new_io_mux_sel;
      end else if (c.cfg_result) begin
         n.res[c.rca_result_mux_addr] = c.new_rca_result_mux_sel;
      end
      return n;
   endfunction

   // Malformed: not exactly one flag, or a grid write aimed past the last mux.
   function automatic logic cfg_invalid(input rca_inputs_t c);
      return ($countones({c.cfg_cpu_reg, c.cfg_grid, c.cfg_io, c.cfg_result}) != 1) ||
             (c.cfg_grid && (c.grid_mux_addr >= GRID_ADDR_W'(NUM_GRID_MUXES)));
   endfunction

endpackage

// File: rtl/rca_config_unit_use_tracker.sv
// rca_use_tracker: per-RCA count of issued-but-not-completed use instructions.
// Ports: clk_i, rst_i (async active-high), issue_i/issue_sel_i, done_i/done_sel_i,
//        zero_o[r] = 1 when RCA r has nothing in flight.
module rca_use_tracker
   import rca_config_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                issue_i,
   input  logic [RCA_W-1:0]    issue_sel_i,
   input  logic                done_i,
   input  logic [RCA_W-1:0]    done_sel_i,
   output logic [NUM_RCAS-1:0] zero_o
);

   logic [CNT_W-1:0]    cnt_q [NUM_RCAS];
   logic [CNT_W-1:0]    cnt_d [NUM_RCAS];
   logic [NUM_RCAS-1:0] inc;
   logic [NUM_RCAS-1:0] dec;

   always_comb begin
      inc    = '0;
      dec    = '0;
      zero_o = '0;
      for (int r = 0; r < NUM_RCAS; r++) begin
         inc[r]    = issue_i && (issue_sel_i == RCA_W'(r));
         dec[r]    = done_i  && (done_sel_i  == RCA_W'(r));
         cnt_d[r]  = cnt_q[r];
         // Simultaneous issue and done cancel out.
         if (inc[r] && !dec[r])
            cnt_d[r] = cnt_q[r] + 1'b1;
         else if (dec[r] && !inc[r] && (cnt_q[r] != '0))
            cnt_d[r] = cnt_q[r] - 1'b1;
         zero_o[r] = (cnt_q[r] == '0);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_RCAS; r++) cnt_q[r] <= '0;
      end else begin
         for (int r = 0; r < NUM_RCAS; r++) cnt_q[r] <= cnt_d[r];
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int r = 0; r < NUM_RCAS; r++)
            assert (!(dec[r] && !inc[r] && (cnt_q[r] == '0)));
      end
   end
`endif

endmodule

// File: rtl/rca_config_unit.sv
// rca_config_unit: applies RCA configuration instructions. Writes go to a
// per-RCA shadow bank; the whole shadow bank is copied to the active bank once
// the target RCA has drained its in-flight use instructions.
// Ports: clk_i, rst_i (async active-high); cfg_valid_i/cfg_ready_o/cfg_i/cfg_id_i
//        config handshake; cfg_done_o/cfg_done_id_o apply pulse; use_issue*/use_done*
//        in-flight tracking; use_stall_o per-RCA issue block; lookup_sel_i/rca_config_o
//        combinational register-address read; *_mux_sels_o active mux selects.
// Build macro RCA_CFG_CHECK_EN: malformed instructions skip the drain, write nothing
//        and raise cfg_err_o alongside cfg_done_o.
//
// state    | meaning
// ST_IDLE  | ready for a config instruction
// ST_DRAIN | shadow written; stalling target RCA until its in-flight count is 0
// ST_APPLY | one cycle: cfg_done, shadow bank copied to active at the edge
module rca_config_unit
   import rca_config_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cfg_valid_i,
   output logic                cfg_ready_o,
   input  rca_inputs_t         cfg_i,
   input  id_t                 cfg_id_i,
   output logic                cfg_done_o,
   output id_t                 cfg_done_id_o,
`ifdef RCA_CFG_CHECK_EN
   output logic                cfg_err_o,
`endif
   input  logic                use_issue_i,
   input  logic [RCA_W-1:0]    use_issue_sel_i,
   input  logic                use_done_i,
   input  logic [RCA_W-1:0]    use_done_sel_i,
   output logic [NUM_RCAS-1:0] use_stall_o,
   input  logic [RCA_W-1:0]    lookup_sel_i,
   output rca_config_t         rca_config_o,
   output logic [NUM_RCAS*NUM_GRID_MUXES*GRID_SEL_W-1:0] grid_mux_sels_o,
   output logic [NUM_RCAS*GRID_NUM_ROWS*IO_SEL_W-1:0]    io_mux_sels_o,
   output logic [NUM_RCAS*NUM_WRITE_PORTS*RES_SEL_W-1:0] result_mux_sels_o
);

   localparam int GRID_BANK_W = NUM_GRID_MUXES * GRID_SEL_W;
   localparam int IO_BANK_W   = GRID_NUM_ROWS * IO_SEL_W;
   localparam int RES_BANK_W  = NUM_WRITE_PORTS * RES_SEL_W;

   rca_cfg_state_t      state_q, state_d;
   logic [RCA_W-1:0]    target_q;
   id_t                 id_q;
   logic                err_q;
   rca_cfg_bank_t       shadow_q [NUM_RCAS];
   rca_cfg_bank_t       active_q [NUM_RCAS];
   logic [NUM_RCAS-1:0] zero;
   logic                accept;
   logic                bad;

   rca_use_tracker u_tracker (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .issue_i     (use_issue_i),
      .issue_sel_i (use_issue_sel_i),
      .done_i      (use_done_i),
      .done_sel_i  (use_done_sel_i),
      .zero_o      (zero)
   );

`ifdef RCA_CFG_CHECK_EN
   assign bad       = cfg_invalid(cfg_i);
   assign cfg_err_o = (state_q == ST_APPLY) && err_q;
`else
   assign bad = 1'b0;
`endif

   assign cfg_ready_o = (state_q == ST_IDLE);
   assign accept      = cfg_valid_i && cfg_ready_o;

   always_comb begin
      state_d       = state_q;
      cfg_done_o    = 1'b0;
      cfg_done_id_o = '0;
      use_stall_o   = '0;
      case (state_q)
         ST_IDLE:  if (accept) state_d = bad ? ST_APPLY : ST_DRAIN;
         ST_DRAIN: begin
            use_stall_o[target_q] = 1'b1;
            if (zero[target_q]) state_d = ST_APPLY;
         end
         ST_APPLY: begin
            cfg_done_o    = 1'b1;
            cfg_done_id_o = id_q;
            state_d       = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         target_q <= '0;
         id_q     <= '0;
         err_q    <= 1'b0;
         for (int r = 0; r < NUM_RCAS; r++) begin
            shadow_q[r] <= '0;
            active_q[r] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (accept) begin
            target_q <= cfg_i.rca_sel;
            id_q     <= cfg_id_i;
            err_q    <= bad;
            if (!bad) shadow_q[cfg_i.rca_sel] <= apply_cfg(shadow_q[cfg_i.rca_sel], cfg_i);
         end
         if ((state_q == ST_APPLY) && !err_q) active_q[target_q] <= shadow_q[target_q];
      end
   end

   always_comb begin
      rca_config_o.src  = active_q[lookup_sel_i].src;
      rca_config_o.dest = active_q[lookup_sel_i].dest;
      grid_mux_sels_o   = '0;
      io_mux_sels_o     = '0;
      result_mux_sels_o = '0;
      for (int r = 0; r < NUM_RCAS; r++) begin
         grid_mux_sels_o[r*GRID_BANK_W +: GRID_BANK_W] = active_q[r].grid;
         io_mux_sels_o[r*IO_BANK_W +: IO_BANK_W]       = active_q[r].io;
         result_mux_sels_o[r*RES_BANK_W +: RES_BANK_W] = active_q[r].res;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!rst_i && use_issue_i) assert (!use_stall_o[use_issue_sel_i]);
   end
`endif

endmodule

// File: tb/tb_rca_config_unit.sv
module tb_rca_config_unit;
   import rca_config_pkg::*;

   logic                clk = 1'b0;
   logic                rst;
   logic                cfg_valid;
   logic                cfg_ready;
   rca_inputs_t         cfg;
   id_t                 cfg_id;
   logic                cfg_done;
   id_t                 cfg_done_id;
   logic                cfg_err;
   logic                use_issue, use_done;
   logic [RCA_W-1:0]    use_issue_sel, use_done_sel, lookup_sel;
   logic [NUM_RCAS-1:0] use_stall;
   rca_config_t         rca_config;
   logic [NUM_RCAS*NUM_GRID_MUXES*GRID_SEL_W-1:0] grid_sels;
   logic [NUM_RCAS*GRID_NUM_ROWS*IO_SEL_W-1:0]    io_sels;
   logic [NUM_RCAS*NUM_WRITE_PORTS*RES_SEL_W-1:0] res_sels;

   int tests = 0;
   int fails = 0;
   logic [3:0] sb_q [$];   // {err, id} expected per accepted config
   rca_inputs_t c;
   logic seen;

   always #5 clk = ~clk;

   rca_config_unit dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .cfg_valid_i       (cfg_valid),
      .cfg_ready_o       (cfg_ready),
      .cfg_i             (cfg),
      .cfg_id_i          (cfg_id),
      .cfg_done_o        (cfg_done),
      .cfg_done_id_o     (cfg_done_id),
`ifdef RCA_CFG_CHECK_EN
      .cfg_err_o         (cfg_err),
`endif
      .use_issue_i       (use_issue),
      .use_issue_sel_i   (use_issue_sel),
      .use_done_i        (use_done),
      .use_done_sel_i    (use_done_sel),
      .use_stall_o       (use_stall),
      .lookup_sel_i      (lookup_sel),
      .rca_config_o      (rca_config),
      .grid_mux_sels_o   (grid_sels),
      .io_mux_sels_o     (io_sels),
      .result_mux_sels_o (res_sels)
   );

`ifndef RCA_CFG_CHECK_EN
   assign cfg_err = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Handshake in the current cycle; returns one cycle later with valid dropped.
   task automatic send(input rca_inputs_t ci, input id_t id, input logic err);
      cfg = ci; cfg_id = id; cfg_valid = 1'b1;
      check("send_ready", {31'd0, cfg_ready}, 32'd1);
      sb_q.push_back({err, id});
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         if (cfg_done) seen = 1'b1;
         else tick();
      end
      check("wait_done_bound", {31'd0, seen}, 32'd1);
   endtask

   // Scoreboard: every cfg_done pulse must match the oldest pending config.
   initial begin
      logic [3:0] exp;
      forever begin
         @(negedge clk);
         if (cfg_done) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
               exp = sb_q.pop_front();
               check("sb_done_id_err", {28'd0, cfg_err, cfg_done_id}, {28'd0, exp});
            end
         end
      end
   end

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg = '0; cfg_id = '0;
      use_issue = 1'b0; use_done = 1'b0; use_issue_sel = '0; use_done_sel = '0; lookup_sel = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_ready", {31'd0, cfg_ready}, 32'd1);
      check("rst_done", {31'd0, cfg_done}, 32'd0);
      check("rst_done_id", {29'd0, cfg_done_id}, 32'd0);
      check("rst_stall", {28'd0, use_stall}, 32'd0);
      check("rst_grid_or", {31'd0, |grid_sels}, 32'd0);
      check("rst_cfg_or", {31'd0, |rca_config}, 32'd0);

      // Reset while draining rca 1 (count 2): config is dropped, nothing pushed.
      use_issue = 1'b1; use_issue_sel = 2'd1; tick(); tick(); use_issue = 1'b0;
      c = '0; c.rca_sel = 2'd1; c.cfg_grid = 1'b1; c.grid_mux_addr = 5'd5; c.new_grid_mux_sel = 3'd6;
      cfg = c; cfg_id = 3'd1; cfg_valid = 1'b1;
      tick(); cfg_valid = 1'b0;
      tick();
      check("drain_stall_rca1", {28'd0, use_stall}, 32'h2);
      #2 rst = 1'b1; #1;
      check("midrst_ready", {31'd0, cfg_ready}, 32'd1);
      check("midrst_stall", {28'd0, use_stall}, 32'd0);
      tick(); rst = 1'b0; tick(); tick();
      check("midrst_grid_or", {31'd0, |grid_sels}, 32'd0);
      check("midrst_done", {31'd0, cfg_done}, 32'd0);

      // cpu_reg src write to rca 2, exact latency.
      lookup_sel = 2'd2;
      c = '0; c.rca_sel = 2'd2; c.cfg_cpu_reg = 1'b1; c.cpu_port_sel = 3'd3; c.cpu_reg_addr = 5'd17;
      send(c, 3'd5, 1'b0);
      check("cpu_drain_stall", {28'd0, use_stall}, 32'h4);
      tick();
      check("cpu_done_n2", {31'd0, cfg_done}, 32'd1);
      check("cpu_done_id_n2", {29'd0, cfg_done_id}, 32'd5);
      check("cpu_src3_before", {27'd0, rca_config.src[3]}, 32'd0);
      tick();
      check("cpu_src3_n3", {27'd0, rca_config.src[3]}, 32'd17);
      check("cpu_dest0", {27'd0, rca_config.dest[0]}, 32'd0);
      check("cpu_ready_n3", {31'd0, cfg_ready}, 32'd1);

      // grid cfg to rca 1 held until two use_done drain count 2 (counters were reset).
      use_issue = 1'b1; use_issue_sel = 2'd1; tick(); tick(); use_issue = 1'b0;
      c = '0; c.rca_sel = 2'd1; c.cfg_grid = 1'b1; c.grid_mux_addr = 5'd5; c.new_grid_mux_sel = 3'd6;
      send(c, 3'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("grid_stall_hold", {27'd0, use_stall, cfg_done}, {27'd0, 4'h2, 1'b0});
         tick();
      end
      use_done = 1'b1; use_done_sel = 2'd1; tick(); tick(); use_done = 1'b0;
      check("grid_not_yet_done", {31'd0, cfg_done}, 32'd0);
      tick();
      check("grid_done", {31'd0, cfg_done}, 32'd1);
      check("grid_sel_before", {29'd0, grid_sels[(1*16+5)*3 +: 3]}, 32'd0);
      tick();
      check("grid_sel_after", {29'd0, grid_sels[(1*16+5)*3 +: 3]}, 32'd6);

      // Same-cycle issue+done on rca 0 keeps count at 1.
      use_issue = 1'b1; use_issue_sel = 2'd0; tick();
      use_done = 1'b1; use_done_sel = 2'd0; tick();
      use_issue = 1'b0; use_done = 1'b0;
      c = '0; c.rca_sel = 2'd0; c.cfg_result = 1'b1; c.rca_result_mux_addr = 1'b1; c.new_rca_result_mux_sel = 2'd3;
      send(c, 3'd3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("same_cycle_hold", {27'd0, use_stall, cfg_done}, {27'd0, 4'h1, 1'b0});
         tick();
      end
      use_done = 1'b1; use_done_sel = 2'd0; tick(); use_done = 1'b0;
      tick();
      check("res_done", {31'd0, cfg_done}, 32'd1);
      tick();
      check("res_sel", {30'd0, res_sels[(0*2+1)*2 +: 2]}, 32'd3);

      // Back-to-back: second config held until the first completes.
      c = '0; c.rca_sel = 2'd3; c.cfg_io = 1'b1; c.io_mux_addr = 2'd2; c.new_io_mux_sel = 3'd5;
      cfg = c; cfg_id = 3'd6; cfg_valid = 1'b1;
      check("b2b_ready_a", {31'd0, cfg_ready}, 32'd1);
      sb_q.push_back({1'b0, 3'd6});
      tick();
      c = '0; c.rca_sel = 2'd3; c.cfg_cpu_reg = 1'b1; c.cpu_src_dest_port = 1'b1; c.cpu_port_sel = 3'd1; c.cpu_reg_addr = 5'd9;
      cfg = c; cfg_id = 3'd7;
      check("b2b_held_drain", {31'd0, cfg_ready}, 32'd0);
      tick();
      check("b2b_held_apply", {31'd0, cfg_ready}, 32'd0);
      check("b2b_a_done", {31'd0, cfg_done}, 32'd1);
      tick();
      check("b2b_accept_idle", {31'd0, cfg_ready}, 32'd1);
      sb_q.push_back({1'b0, 3'd7});
      tick(); cfg_valid = 1'b0;
      tick();
      check("b2b_b_done", {31'd0, cfg_done}, 32'd1);
      tick();
      lookup_sel = 2'd3; #1;
      check("b2b_io", {29'd0, io_sels[(3*4+2)*3 +: 3]}, 32'd5);
      check("b2b_dest1", {27'd0, rca_config.dest[1]}, 32'd9);

      // grid + io flags together.
      c = '0; c.rca_sel = 2'd0; c.cfg_grid = 1'b1; c.cfg_io = 1'b1;
      c.grid_mux_addr = 5'd2; c.new_grid_mux_sel = 3'd7; c.io_mux_addr = 2'd1; c.new_io_mux_sel = 3'd4;
`ifdef RCA_CFG_CHECK_EN
      send(c, 3'd4, 1'b1);
      check("multi_err_done", {30'd0, cfg_done, cfg_err}, 32'd3);
      tick();
      check("multi_err_grid", {29'd0, grid_sels[(0*16+2)*3 +: 3]}, 32'd0);
      check("multi_err_io", {29'd0, io_sels[(0*4+1)*3 +: 3]}, 32'd0);
      c = '0; c.rca_sel = 2'd0; c.cfg_io = 1'b1; c.io_mux_addr = 2'd3; c.new_io_mux_sel = 3'd1;
      send(c, 3'd1, 1'b0);
      wait_done(8);
      tick();
      check("multi_err_shadow_grid", {29'd0, grid_sels[(0*16+2)*3 +: 3]}, 32'd0);
      check("multi_err_shadow_io", {29'd0, io_sels[(0*4+3)*3 +: 3]}, 32'd1);
`else
      send(c, 3'd4, 1'b0);
      tick();
      check("prio_done", {31'd0, cfg_done}, 32'd1);
      tick();
      check("prio_grid_wins", {29'd0, grid_sels[(0*16+2)*3 +: 3]}, 32'd7);
      check("prio_io_skipped", {29'd0, io_sels[(0*4+1)*3 +: 3]}, 32'd0);
`endif

      // Out-of-range grid address: no write to any grid mux of rca 2.
      c = '0; c.rca_sel = 2'd2; c.cfg_grid = 1'b1; c.grid_mux_addr = 5'd20; c.new_grid_mux_sel = 3'd7;
`ifdef RCA_CFG_CHECK_EN
      send(c, 3'd0, 1'b1);
`else
      send(c, 3'd0, 1'b0);
`endif
      wait_done(8);
      tick();
      check("oor_grid_rca2", {31'd0, |grid_sels[2*48 +: 48]}, 32'd0);

      tick(); tick();
      check("sb_empty", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
